// File: rtl/mem_responder.sv
// Single-port 32x8 memory responder with a request/ready handshake.
// A configurable number of wait states separates acceptance and response.
module mem_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       ir_on_adr,
  input  logic       pc_on_adr,
  input  logic [4:0] ir_adr,
  input  logic [4:0] pc_adr,
  input  logic [7:0] data_in,
  input  logic       prog_we,
  input  logic [4:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] data_out,
  output logic       mem_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;

  logic       lat_write;
  logic [4:0] lat_addr;
  logic [7:0] lat_data;

  logic [7:0] mem [32];

  logic       is_idle;
  logic       strobe;
  logic       op_one;
  logic       sel_one;
  logic       accept;
  logic       reject;
  logic [4:0] sel_addr;

  logic       do_access;
  logic       acc_write;
  logic [4:0] acc_addr;
  logic [7:0] acc_data;

  assign is_idle  = (state == S_IDLE);
  assign strobe   = mem_read | mem_write;
  assign op_one   = mem_read ^ mem_write;
  assign sel_one  = ir_on_adr ^ pc_on_adr;
  assign sel_addr = ir_on_adr ? ir_adr : pc_adr;

  // A loader write takes priority; the request is simply re-evaluated later.
  assign accept = is_idle & op_one & sel_one & ~prog_we;
  assign reject = is_idle & strobe & ~(op_one & sel_one) & ~prog_we;

  // With zero wait states the access happens on the accept edge,
  // so the live inputs are used instead of the latched copies.
  assign do_access = (state != S_RESP) & (state_nxt == S_RESP);
  assign acc_write = is_idle ? mem_write : lat_write;
  assign acc_addr  = is_idle ? sel_addr  : lat_addr;
  assign acc_data  = is_idle ? data_in   : lat_data;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    mem_ready = (state == S_RESP);
    busy      = (state != S_IDLE);
  end

  // Wait-state counter, loaded on accept and run down in WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 3'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == S_WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Capture the request so later input changes are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= 5'd0;
      lat_data  <= 8'h00;
    end else if (accept) begin
      lat_write <= mem_write;
      lat_addr  <= sel_addr;
      lat_data  <= data_in;
    end
  end

  // Malformed-request pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= reject;
    end
  end

  // Read data register, updated only by a completed read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (do_access && !acc_write) begin
      data_out <= mem[acc_addr];
    end
  end

  // Storage array: access writes and loader writes never coincide
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_access && acc_write) begin
      mem[acc_addr] <= acc_data;
    end else if (is_idle && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at four wait-state settings.
// Stimulus pushes expected read data; a monitor checks on mem_ready.
module tb_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst  [4];
  logic       rd   [4];
  logic       wr   [4];
  logic       iro  [4];
  logic       pco  [4];
  logic [4:0] iadr [4];
  logic [4:0] padr [4];
  logic [7:0] din  [4];
  logic       pwe  [4];
  logic [4:0] paddr[4];
  logic [7:0] pdat [4];
  logic [7:0] dout [4];
  logic       rdy  [4];
  logic       bsy  [4];
  logic       er   [4];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         k;
    logic [7:0] d;
  } exp_t;

  exp_t sq[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    mem_responder #(.WAIT_CYCLES(W)) u_dut (
      .clock    (clock),
      .reset    (rst[g]),
      .mem_read (rd[g]),
      .mem_write(wr[g]),
      .ir_on_adr(iro[g]),
      .pc_on_adr(pco[g]),
      .ir_adr   (iadr[g]),
      .pc_adr   (padr[g]),
      .data_in  (din[g]),
      .prog_we  (pwe[g]),
      .prog_addr(paddr[g]),
      .prog_data(pdat[g]),
      .data_out (dout[g]),
      .mem_ready(rdy[g]),
      .busy     (bsy[g]),
      .err      (er[g])
    );
  end

  function automatic int wcyc(input int k);
    case (k)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input int k, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", k, nm, act, exp);
    end
  endtask

  // Monitor: every mem_ready pops one expected response
  always @(negedge clock) begin : mon
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rdy[k] === 1'b1) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL dut%0d unexpected_ready: got %0h expected none",
                   k, dout[k]);
        end else begin
          e = sq.pop_front();
          if (e.k != k || dout[k] !== e.d) begin
            errors++;
            $display("FAIL dut%0d resp_data: got %0h (dut%0d) expected %0h (dut%0d)",
                     k, dout[k], k, e.d, e.k);
          end
        end
      end
    end
  end

  task automatic clear_req(input int k);
    rd[k]  = 1'b0;
    wr[k]  = 1'b0;
    iro[k] = 1'b0;
    pco[k] = 1'b0;
  endtask

  // Wait for the response after the accept edge; scramble inputs meanwhile
  task automatic wait_resp(input int k);
    int  cyc  = 0;
    int  bcnt = 0;
    bit  seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bsy[k] === 1'b1) bcnt++;
      if (rdy[k] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      din[k]  = 8'hFF;
      iadr[k] = ~iadr[k];
      padr[k] = ~padr[k];
      cyc++;
      @(posedge clock);
    end
    clear_req(k);
    chk(k, "ready_seen", 32'(seen), 32'd1);
    chk(k, "latency", cyc, wcyc(k));
    chk(k, "busy_cycles", bcnt, (wcyc(k) == 0) ? 1 : wcyc(k) + 1);
    @(negedge clock);
    chk(k, "ready_pulse_end", 32'(rdy[k]), 32'd0);
    chk(k, "busy_end", 32'(bsy[k]), 32'd0);
  endtask

  task automatic do_req(input int k, input logic r, input logic w,
                        input logic i, input logic p,
                        input logic [4:0] ia, input logic [4:0] pa,
                        input logic [7:0] d, input logic [7:0] exp);
    exp_t e;
    rd[k]   = r;
    wr[k]   = w;
    iro[k]  = i;
    pco[k]  = p;
    iadr[k] = ia;
    padr[k] = pa;
    din[k]  = d;
    e.k = k;
    e.d = exp;
    sq.push_back(e);
    @(posedge clock);
    wait_resp(k);
  endtask

  task automatic prog(input int k, input logic [4:0] a, input logic [7:0] d);
    pwe[k]   = 1'b1;
    paddr[k] = a;
    pdat[k]  = d;
    @(posedge clock);
    @(negedge clock);
    pwe[k] = 1'b0;
    chk(k, "prog_busy", 32'(bsy[k]), 32'd0);
  endtask

  task automatic bad_req(input int k, input logic r, input logic w,
                         input logic i, input logic p,
                         input logic [7:0] keep);
    rd[k]   = r;
    wr[k]   = w;
    iro[k]  = i;
    pco[k]  = p;
    iadr[k] = 5'd5;
    padr[k] = 5'd5;
    din[k]  = 8'h11;
    @(posedge clock);
    @(negedge clock);
    chk(k, "bad_err", 32'(er[k]), 32'd1);
    chk(k, "bad_busy", 32'(bsy[k]), 32'd0);
    chk(k, "bad_ready", 32'(rdy[k]), 32'd0);
    clear_req(k);
    @(negedge clock);
    chk(k, "bad_err_end", 32'(er[k]), 32'd0);
    chk(k, "bad_dout", 32'(dout[k]), 32'(keep));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      clear_req(k);
      iadr[k]  = 5'd0;
      padr[k]  = 5'd0;
      din[k]   = 8'h00;
      pwe[k]   = 1'b0;
      paddr[k] = 5'd0;
      pdat[k]  = 8'h00;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      chk(k, "rst_dout", 32'(dout[k]), 32'd0);
      chk(k, "rst_ready", 32'(rdy[k]), 32'd0);
      chk(k, "rst_busy", 32'(bsy[k]), 32'd0);
      chk(k, "rst_err", 32'(er[k]), 32'd0);
      rst[k] = 1'b0;
    end
    @(negedge clock);

    // One wait state: load, read, write, readback, malformed requests
    prog(1, 5'd5, 8'hA7);
    do_req(1, 1, 0, 1, 0, 5'd5, 5'd0, 8'h00, 8'hA7);
    do_req(1, 0, 1, 0, 1, 5'd0, 5'd31, 8'h3C, 8'hA7);
    do_req(1, 1, 0, 0, 1, 5'd0, 5'd31, 8'h00, 8'h3C);
    bad_req(1, 1, 1, 1, 0, 8'h3C);
    bad_req(1, 1, 0, 1, 1, 8'h3C);
    bad_req(1, 0, 1, 0, 0, 8'h3C);
    do_req(1, 1, 0, 1, 0, 5'd5, 5'd0, 8'h00, 8'hA7);

    // Loader write and read in the same idle cycle
    pwe[1]   = 1'b1;
    paddr[1] = 5'd12;
    pdat[1]  = 8'h6D;
    rd[1]    = 1'b1;
    iro[1]   = 1'b1;
    iadr[1]  = 5'd12;
    e.k = 1;
    e.d = 8'h6D;
    sq.push_back(e);
    @(posedge clock);
    @(negedge clock);
    chk(1, "prog_rd_busy", 32'(bsy[1]), 32'd0);
    chk(1, "prog_rd_err", 32'(er[1]), 32'd0);
    pwe[1] = 1'b0;
    @(posedge clock);
    wait_resp(1);

    // Zero wait states
    prog(0, 5'd3, 8'h5E);
    do_req(0, 1, 0, 1, 0, 5'd3, 5'd0, 8'h00, 8'h5E);
    do_req(0, 0, 1, 0, 1, 5'd0, 5'd7, 8'h99, 8'h5E);
    do_req(0, 1, 0, 1, 0, 5'd7, 5'd0, 8'h00, 8'h99);

    // Seven wait states
    do_req(3, 0, 1, 1, 0, 5'd0, 5'd0, 8'h42, 8'h00);
    do_req(3, 1, 0, 0, 1, 5'd0, 5'd0, 8'h00, 8'h42);

    // Three wait states: reset abandons a pending write
    prog(2, 5'd9, 8'h77);
    do_req(2, 1, 0, 1, 0, 5'd9, 5'd0, 8'h00, 8'h77);
    wr[2]   = 1'b1;
    pco[2]  = 1'b1;
    padr[2] = 5'd9;
    din[2]  = 8'h5A;
    @(posedge clock);
    @(negedge clock);
    chk(2, "pre_rst_busy", 32'(bsy[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    chk(2, "async_rst_dout", 32'(dout[2]), 32'd0);
    chk(2, "async_rst_busy", 32'(bsy[2]), 32'd0);
    chk(2, "async_rst_ready", 32'(rdy[2]), 32'd0);
    chk(2, "async_rst_err", 32'(er[2]), 32'd0);
    clear_req(2);
    @(negedge clock);
    rst[2] = 1'b0;
    repeat (6) @(negedge clock);
    do_req(2, 1, 0, 1, 0, 5'd9, 5'd0, 8'h00, 8'h00);

    repeat (2) @(negedge clock);
    chk(0, "queue_empty", 32'(sq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
